// File: rtl/ysyx_22041211_sram_rd_pkg.sv
// Shared definitions for the SRAM read slave: FSM state encoding and
// read-response codes.
// Optional error checking is enabled by defining YSYX_22041211_SRAM_RD_ERR_EN.
package ysyx_22041211_sram_rd_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,  // ready to accept a read request
    WAIT = 2'd1,  // counting down the access latency
    RESP = 2'd2   // holding the response until the initiator takes it
  } state_t;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

endpackage

// File: rtl/ysyx_22041211_sram_array.sv
// Word storage for the SRAM read slave: one write port, one read port whose
// output register is loaded only when ren is high (sync-sampled).
// Ports: clk, rst (async active-low, clears the read register only),
//   wen/widx/wdata (write), ren/rzero/ridx/rdata (sampled read).
// Contents are never reset. A write and a sample of the same word on the
// same edge return the old word.
module ysyx_22041211_sram_array #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 1024,
  parameter int IDX_W      = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wen,
  input  logic [IDX_W-1:0]      widx,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  ren,
  input  logic                  rzero,
  input  logic [IDX_W-1:0]      ridx,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wen) begin
      mem[widx] <= wdata;
    end
  end

  // rzero lets the caller return an all-zero word for rejected accesses
  // without touching the array.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rdata <= '0;
    end else if (ren) begin
      rdata <= rzero ? '0 : mem[ridx];
    end
  end

endmodule

// File: rtl/ysyx_22041211_sram_rd.sv
// Single-outstanding SRAM read slave with an AR/R style handshake, a
// programmable access latency (LATENCY wait cycles, 1..15) and a side load port.
// Ports: clk, rst (async active-low); wen/waddr/wdata load port;
//   araddr/arvalid/arready read request; rdata/rresp/rvalid/rready response.
// Define YSYX_22041211_SRAM_RD_ERR_EN to answer out-of-range word indices with
// SLVERR and zero data and to drop out-of-range writes; otherwise addresses wrap.
module ysyx_22041211_sram_rd
  import ysyx_22041211_sram_rd_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 1024,
  parameter int LATENCY    = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wen,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [ADDR_WIDTH-1:0] araddr,
  input  logic                  arvalid,
  output logic                  arready,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic [1:0]            rresp,
  output logic                  rvalid,
  input  logic                  rready
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

  state_t                state, state_nxt;
  logic [3:0]            cnt;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic                  ar_hs;
  logic                  sample;
  logic                  w_oob;
  logic                  r_oob;

  assign ar_hs  = arvalid && arready;
  assign sample = (state == WAIT) && (cnt == 4'd0);

`ifdef YSYX_22041211_SRAM_RD_ERR_EN
  // Any set bit above the word index means the word lies past DEPTH.
  assign w_oob = |waddr[ADDR_WIDTH-1:IDX_W+2];
  assign r_oob = |addr_q[ADDR_WIDTH-1:IDX_W+2];

  logic unused_addr_bits;
  assign unused_addr_bits = ^{waddr[1:0], addr_q[1:0]};
`else
  assign w_oob = 1'b0;
  assign r_oob = 1'b0;

  // Upper bits are dropped so addresses wrap modulo DEPTH.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{waddr[1:0], addr_q[1:0],
                              waddr[ADDR_WIDTH-1:IDX_W+2],
                              addr_q[ADDR_WIDTH-1:IDX_W+2]};
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    arready   = 1'b0;
    rvalid    = 1'b0;
    case (state)
      IDLE: begin
        arready = 1'b1;
        if (arvalid) state_nxt = WAIT;
      end
      WAIT: begin
        if (cnt == 4'd0) state_nxt = RESP;
      end
      RESP: begin
        rvalid = 1'b1;
        if (rready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt    <= 4'd0;
      addr_q <= '0;
      rresp  <= RESP_OKAY;
    end else begin
      if (ar_hs) begin
        addr_q <= araddr;
        cnt    <= CNT_LOAD;
      end else if (state == WAIT && cnt != 4'd0) begin
        cnt <= cnt - 4'd1;
      end
      if (sample) begin
        rresp <= r_oob ? RESP_SLVERR : RESP_OKAY;
      end
    end
  end

  ysyx_22041211_sram_array #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH),
    .IDX_W      (IDX_W)
  ) u_array (
    .clk   (clk),
    .rst   (rst),
    .wen   (wen && !w_oob),
    .widx  (waddr[IDX_W+1:2]),
    .wdata (wdata),
    .ren   (sample),
    .rzero (r_oob),
    .ridx  (addr_q[IDX_W+1:2]),
    .rdata (rdata)
  );

endmodule

// File: doc/ysyx_22041211_sram_rd.md
YSYX_22041211_SRAM_RD -- requirements
Module: ysyx_22041211_sram_rd

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32, byte-address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, word width.
REQ-003 SHALL have parameter DEPTH, default 1024, number of words, power of two.
REQ-004 SHALL have parameter LATENCY, default 1, wait cycles, legal range 1..15.
REQ-005 SHALL have port clk  in  1  single clock, all state on posedge.
REQ-006 SHALL have port rst  in  1  asynchronous active-low reset.
REQ-007 SHALL have port wen  in  1  load-port write enable.
REQ-008 SHALL have port waddr  in  ADDR_WIDTH  load-port byte address.
REQ-009 SHALL have port wdata  in  DATA_WIDTH  load-port data.
REQ-010 SHALL have port araddr  in  ADDR_WIDTH  read request byte address.
REQ-011 SHALL have port arvalid  in  1  read request valid.
REQ-012 SHALL have port arready  out  1  read request accepted.
REQ-013 SHALL have port rdata  out  DATA_WIDTH  read data.
REQ-014 SHALL have port rresp  out  2  response code, 2'b00 OKAY, 2'b10 SLVERR.
REQ-015 SHALL have port rvalid  out  1  read data valid.
REQ-016 SHALL have port rready  in  1  read data accepted by initiator.

Function
REQ-017 SHALL implement FSM states IDLE, WAIT, RESP.
REQ-018 SHALL drive arready=1 only in IDLE; AR handshake = arvalid&&arready.
REQ-019 SHALL, on AR handshake, latch araddr, load 4-bit counter with LATENCY-1, go to WAIT.
REQ-020 SHALL, in WAIT with counter!=0, decrement counter each cycle.
REQ-021 SHALL, in WAIT with counter==0, sample the array into rdata/rresp and go to RESP.
REQ-022 SHALL first assert rvalid in cycle k+1+LATENCY, where k is the AR handshake cycle.
REQ-023 SHALL hold rvalid, rdata, rresp stable in RESP until rvalid&&rready; then go to IDLE.
REQ-024 SHALL accept at most one outstanding request; next arready is high the cycle after R handshake.
REQ-025 SHALL ignore address bits [1:0]; word index = addr[log2(DEPTH)+1:2].
REQ-026 SHALL write wdata to word index of waddr on posedge when wen=1, in any state.
REQ-027 SHALL return old word data when wen targets the sampled word in the sampling cycle.
REQ-028 SHALL return new data when the write occurs in any cycle before the sampling cycle.
REQ-029 SHALL ignore arvalid in WAIT and RESP (no latch, no side effect).

Reset
REQ-030 SHALL, while rst=0, force IDLE, rvalid=0, rdata=0, rresp=2'b00, counter=0, latched address=0.
REQ-031 SHALL abandon any in-flight request on reset; no response issued for it after release.
REQ-032 SHALL leave array contents undefined/unchanged by reset.
REQ-033 SHALL drive arready=1 in the first cycle after reset release.

Configuration
REQ-034 SHALL, with YSYX_22041211_SRAM_RD_ERR_EN defined, return rresp=2'b10 and rdata=0 for word index >= DEPTH (upper address bits nonzero), and ignore such writes.
REQ-035 SHALL, without YSYX_22041211_SRAM_RD_ERR_EN, wrap address modulo DEPTH and always return rresp=2'b00.

Structure
REQ-036 SHALL place FSM state encodings and rresp codes (OKAY, SLVERR) in the shared package/header.
REQ-037 SHALL isolate storage in one sub-module ysyx_22041211_sram_array (one write port, one sync-sampled read port).

Verification
REQ-038 Load 0x10->0xDEADBEEF, LATENCY=1, AR 0x10 at cycle 5 with rready=1 -> rvalid cycle 7, rdata=0xDEADBEEF, rresp=00, arready high cycle 8.
REQ-039 LATENCY=4, AR 0x20, rready=0 for 3 cycles after rvalid -> rvalid first in k+5, rdata/rresp stable, clears the cycle after rready=1.
REQ-040 AR 0x30 (old 0x1), wen 0x30 data 0x2 in sampling cycle -> rdata=0x1; wen one cycle earlier -> rdata=0x2.
REQ-041 Assert rst=0 in WAIT, release, keep rready=1 -> no rvalid for aborted request, arready=1 first cycle after release.
REQ-042 DEPTH=1024, AR 0x1000 -> with ERR_EN rresp=10, rdata=0; without, rdata equals word at 0x0000, rresp=00.
REQ-043 arvalid held high continuously with rready=1, LATENCY=2 -> one response every 4 cycles, arready never high in WAIT/RESP.
